// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl: parses UART byte frames (AA addr data = write, BB addr = read) into register-file strobes.
// Optional CMD_ERR_RESP_EN: unknown opcodes and read timeouts answer with an 0xEE byte via ERR_SEND.
module reg_cmd_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
    parameter int                    RD_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    input  logic                  tx_busy,
    output logic                  WrEN,
    output logic                  RdEN,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  busy,
    output logic                  rd_timeout
);

    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(RD_TIMEOUT);
`ifdef CMD_ERR_RESP_EN
    localparam logic [DATA_WIDTH-1:0] ERR_BYTE = DATA_WIDTH'(8'hEE);
`endif

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_REQ,
        RD_WAIT,
        TX_SEND
`ifdef CMD_ERR_RESP_EN
        , ERR_SEND
`endif
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] address_nxt;
    logic [DATA_WIDTH-1:0] wr_data_nxt, tx_data_nxt, rd_buf, rd_buf_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt, cnt_inc;
    logic                  wr_en_nxt, rd_en_nxt, tx_valid_nxt, rd_timeout_nxt;

    assign cnt_inc = cnt + CNT_W'(1);

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt      = state;
        address_nxt    = address;
        wr_data_nxt    = WrData;
        tx_data_nxt    = tx_data;
        rd_buf_nxt     = rd_buf;
        cnt_nxt        = cnt;
        wr_en_nxt      = 1'b0;
        rd_en_nxt      = 1'b0;
        tx_valid_nxt   = 1'b0;
        rd_timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == WR_CMD)      state_nxt = WR_ADDR;
                    else if (rx_data == RD_CMD) state_nxt = RD_ADDR;
`ifdef CMD_ERR_RESP_EN
                    else                        state_nxt = ERR_SEND;
`endif
                end
            end
            WR_ADDR: begin
                if (rx_valid) begin
                    address_nxt = rx_data[ADDR_WIDTH-1:0];
                    state_nxt   = WR_DATA;
                end
            end
            WR_DATA: begin
                if (rx_valid) begin
                    wr_data_nxt = rx_data;
                    wr_en_nxt   = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            RD_ADDR: begin
                if (rx_valid) begin
                    address_nxt = rx_data[ADDR_WIDTH-1:0];
                    rd_en_nxt   = 1'b1;
                    state_nxt   = RD_REQ;
                end
            end
            RD_REQ: begin
                cnt_nxt   = '0;
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                // Data arriving on the final wait cycle still wins over the timeout.
                if (RdData_Valid) begin
                    rd_buf_nxt = RdData;
                    state_nxt  = TX_SEND;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CNT_LIMIT) begin
                        rd_timeout_nxt = 1'b1;
`ifdef CMD_ERR_RESP_EN
                        state_nxt      = ERR_SEND;
`else
                        state_nxt      = IDLE;
`endif
                    end
                end
            end
            TX_SEND: begin
                if (!tx_busy) begin
                    tx_data_nxt  = rd_buf;
                    tx_valid_nxt = 1'b1;
                    state_nxt    = IDLE;
                end
            end
`ifdef CMD_ERR_RESP_EN
            ERR_SEND: begin
                if (!tx_busy) begin
                    tx_data_nxt  = ERR_BYTE;
                    tx_valid_nxt = 1'b1;
                    state_nxt    = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            address    <= '0;
            WrData     <= '0;
            tx_data    <= '0;
            rd_buf     <= '0;
            cnt        <= '0;
            WrEN       <= 1'b0;
            RdEN       <= 1'b0;
            tx_valid   <= 1'b0;
            rd_timeout <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            address    <= address_nxt;
            WrData     <= wr_data_nxt;
            tx_data    <= tx_data_nxt;
            rd_buf     <= rd_buf_nxt;
            cnt        <= cnt_nxt;
            WrEN       <= wr_en_nxt;
            RdEN       <= rd_en_nxt;
            tx_valid   <= tx_valid_nxt;
            rd_timeout <= rd_timeout_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

endmodule
